// File: rtl/apb_bridge_pkg.sv
// Shared types for the APB3 master sequencer: FSM state encoding,
// grant direction and the two APB response codes it produces.
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_SETUP,
        SEQ_ACCESS,
        SEQ_DERR
    } seq_state_t;

    typedef enum logic {
        GNT_WRITE,
        GNT_READ
    } grant_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [1:0] apb_resp(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin arbiter (bit 0 = write, bit 1 = read).
// Ports: clk_i/rst_i, req_i[1:0], advance_i (commit grant), gnt_o[1:0].
module apb_rr_arbiter
    import apb_bridge_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    grant_t last_q;
    grant_t last_d;

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Contention: favour whoever did not win last time.
            2'b11:   gnt_o = (last_q == GNT_READ) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (advance_i && gnt_o[0]) begin
            last_d = GNT_WRITE;
        end else if (advance_i && gnt_o[1]) begin
            last_d = GNT_READ;
        end
    end

    // Reset to READ so that the first contended grant goes to the write side.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= GNT_READ;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb3_master_sequencer.sv
// APB3 master: pops AXI4-Lite write/read commands from FWFT FIFOs, runs
// them one at a time on a shared APB3 bus and returns BRESP / read data.
// Ports: ACLK/ARESET; wcmd_* and rcmd_* command FIFO heads and pops;
// rdata_* read-result FIFO push; bresp_* write-response handshake;
// PADDR/PSEL/PENABLE/PWRITE/PWDATA out, PRDATA/PREADY/PSLVERR per slave.
module apb3_master_sequencer
    import apb_bridge_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS        = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SLV_SEL_LSB    = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic                             wcmd_empty,
    input  logic [ADDRESS-1:0]               wcmd_addr,
    input  logic [DATA_WIDTH-1:0]            wcmd_data,
    output logic                             wcmd_rd_en,
    input  logic                             rcmd_empty,
    input  logic [ADDRESS-1:0]               rcmd_addr,
    output logic                             rcmd_rd_en,
    input  logic                             rdata_full,
    output logic                             rdata_wr_en,
    output logic [DATA_WIDTH-1:0]            rdata_wdata,
    output logic [1:0]                       rdata_resp,
    output logic                             bresp_valid,
    output logic [1:0]                       bresp_resp,
    input  logic                             bresp_ready,
    output logic [ADDRESS-1:0]               PADDR,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    // The slave field is one index wider than needed for the slaves
    // themselves, so an address pointing past the last slave is caught
    // as a decode error instead of silently aliasing onto slave 0.
    localparam int IDXW = $clog2(NUM_SLAVES + 1);
    localparam int CNTW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDXW-1:0] IDX_LIMIT = IDXW'(NUM_SLAVES);

    seq_state_t state_q;

    logic [ADDRESS-1:0]    paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [NUM_SLAVES-1:0] psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic                  wr_q;
    logic [IDXW-1:0]       sel_q;
    logic [CNTW-1:0]       cnt_q;

    logic                  rdata_wr_en_q;
    logic [DATA_WIDTH-1:0] rdata_wdata_q;
    logic [1:0]            rdata_resp_q;
    logic                  bresp_valid_q;
    logic [1:0]            bresp_resp_q;

    logic                  idle_ok;
    logic [1:0]            req;
    logic [1:0]            gnt;
    logic [ADDRESS-1:0]    head_addr;
    logic [IDXW-1:0]       head_idx;
    logic                  head_derr;

    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    logic                  done;
    logic [1:0]            done_resp;
    logic [DATA_WIDTH-1:0] done_data;

    // Arbitration is only live in IDLE, so gnt doubles as the FIFO pop.
    assign idle_ok = (state_q == SEQ_IDLE) && !ARESET;
    assign req[0]  = idle_ok && !wcmd_empty && !bresp_valid_q;
    assign req[1]  = idle_ok && !rcmd_empty && !rdata_full;

    apb_rr_arbiter u_arb (
        .clk_i     (ACLK),
        .rst_i     (ARESET),
        .req_i     (req),
        .advance_i (idle_ok),
        .gnt_o     (gnt)
    );

    assign wcmd_rd_en = gnt[0];
    assign rcmd_rd_en = gnt[1];

    assign head_addr = gnt[0] ? wcmd_addr : rcmd_addr;
    assign head_idx  = head_addr[SLV_SEL_LSB +: IDXW];
    assign head_derr = (head_idx >= IDX_LIMIT);

    // Only the captured slave's handshake and data are looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == IDXW'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        done      = 1'b0;
        done_resp = RESP_SLVERR;
        done_data = '0;
        unique case (state_q)
            SEQ_ACCESS: begin
                if (sel_ready) begin
                    done      = 1'b1;
                    done_resp = apb_resp(sel_err);
                    done_data = sel_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    done = 1'b1;
                end
            end
            SEQ_DERR: done = 1'b1;
            default:  done = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= SEQ_IDLE;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            wr_q          <= 1'b0;
            sel_q         <= '0;
            cnt_q         <= '0;
            rdata_wr_en_q <= 1'b0;
            rdata_wdata_q <= '0;
            rdata_resp_q  <= RESP_OKAY;
            bresp_valid_q <= 1'b0;
            bresp_resp_q  <= RESP_OKAY;
        end else begin
            rdata_wr_en_q <= 1'b0;
            if (bresp_ready) begin
                bresp_valid_q <= 1'b0;
            end
            if (done) begin
                if (wr_q) begin
                    bresp_valid_q <= 1'b1;
                    bresp_resp_q  <= done_resp;
                end else begin
                    rdata_wr_en_q <= 1'b1;
                    rdata_wdata_q <= done_data;
                    rdata_resp_q  <= done_resp;
                end
            end
            unique case (state_q)
                SEQ_IDLE: begin
                    if (|gnt) begin
                        wr_q  <= gnt[0];
                        sel_q <= head_idx;
                        if (head_derr) begin
                            state_q <= SEQ_DERR;
                        end else begin
                            state_q  <= SEQ_SETUP;
                            psel_q   <= NUM_SLAVES'(1) << head_idx;
                            paddr_q  <= head_addr;
                            pwrite_q <= gnt[0];
                            if (gnt[0]) begin
                                pwdata_q <= wcmd_data;
                            end
                        end
                    end
                end
                SEQ_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= SEQ_ACCESS;
                end
                SEQ_ACCESS: begin
                    if (done) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= SEQ_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SEQ_DERR: state_q <= SEQ_IDLE;
                default:  state_q <= SEQ_IDLE;
            endcase
        end
    end

    assign PADDR       = paddr_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign rdata_wr_en = rdata_wr_en_q;
    assign rdata_wdata = rdata_wdata_q;
    assign rdata_resp  = rdata_resp_q;
    assign bresp_valid = bresp_valid_q;
    assign bresp_resp  = bresp_resp_q;

endmodule

// File: tb/tb_apb3_master_sequencer.sv
// Scoreboard bench for apb3_master_sequencer: FIFO and slave models,
// directed cases and a randomized run against a command-level model.
module tb_apb3_master_sequencer;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NS  = 4;
    localparam int LSB = 12;
    localparam int TO  = 256;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic            wcmd_empty = 1'b1;
    logic [AW-1:0]   wcmd_addr = '0;
    logic [DW-1:0]   wcmd_data = '0;
    logic            wcmd_rd_en;
    logic            rcmd_empty = 1'b1;
    logic [AW-1:0]   rcmd_addr = '0;
    logic            rcmd_rd_en;
    logic            rdata_full = 1'b0;
    logic            rdata_wr_en;
    logic [DW-1:0]   rdata_wdata;
    logic [1:0]      rdata_resp;
    logic            bresp_valid;
    logic [1:0]      bresp_resp;
    logic            bresp_ready = 1'b1;
    logic [AW-1:0]   PADDR;
    logic [NS-1:0]   PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [DW-1:0]   PWDATA;
    logic [NS*DW-1:0] PRDATA = '0;
    logic [NS-1:0]   PREADY = '0;
    logic [NS-1:0]   PSLVERR = '0;

    always #5 ACLK = ~ACLK;

    apb3_master_sequencer #(
        .DATA_WIDTH(DW), .ADDRESS(AW), .NUM_SLAVES(NS),
        .SLV_SEL_LSB(LSB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .wcmd_empty(wcmd_empty), .wcmd_addr(wcmd_addr),
        .wcmd_data(wcmd_data), .wcmd_rd_en(wcmd_rd_en),
        .rcmd_empty(rcmd_empty), .rcmd_addr(rcmd_addr),
        .rcmd_rd_en(rcmd_rd_en),
        .rdata_full(rdata_full), .rdata_wr_en(rdata_wr_en),
        .rdata_wdata(rdata_wdata), .rdata_resp(rdata_resp),
        .bresp_valid(bresp_valid), .bresp_resp(bresp_resp),
        .bresp_ready(bresp_ready),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        bit          err;
        logic [31:0] rdata;
    } cmd_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat;
    } exp_t;

    cmd_t wq[$];
    cmd_t rq[$];
    exp_t wexp[$];
    exp_t rexp[$];
    int   wgnt[$];
    int   rgnt[$];
    bit   glog[$];
    cmd_t cur;
    int   wl = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bready_mode = 1;
    bit   full_rand = 1'b0;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Slave field is three bits wide, so indices 4..7 address no slave.
    function automatic int slv_idx(logic [31:0] a);
        return int'((a >> LSB) & 32'h7);
    endfunction

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endfunction

    task automatic issue(bit wr, logic [31:0] addr, logic [31:0] data,
                         int waits, bit err, logic [31:0] rdata);
        cmd_t c;
        exp_t e;
        c.wr = wr; c.addr = addr; c.data = data;
        c.waits = waits; c.err = err; c.rdata = rdata;
        if (slv_idx(addr) >= NS) begin
            e.resp = 2'b10; e.data = '0; e.lat = 2;
        end else if (waits >= TO) begin
            e.resp = 2'b10; e.data = '0; e.lat = 2 + TO;
        end else begin
            e.resp = err ? 2'b10 : 2'b00;
            e.data = wr ? 32'h0 : rdata;
            e.lat  = 3 + waits;
        end
        if (wr) begin
            wq.push_back(c);
            wexp.push_back(e);
        end else begin
            rq.push_back(c);
            rexp.push_back(e);
        end
    endtask

    // Driver: command FIFO heads, slave behaviour, response backpressure.
    initial begin
        int idx;
        forever begin
            @(negedge ACLK);
            wcmd_empty = (wq.size() == 0);
            if (wq.size() > 0) begin
                wcmd_addr = wq[0].addr;
                wcmd_data = wq[0].data;
            end
            rcmd_empty = (rq.size() == 0);
            if (rq.size() > 0) rcmd_addr = rq[0].addr;
            rdata_full = full_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            bresp_ready = (bready_mode == 0) ? 1'b0 :
                          (bready_mode == 1) ? 1'b1 :
                          1'($urandom_range(0, 1));
            PREADY  = NS'($urandom);
            PSLVERR = NS'($urandom);
            PRDATA  = {$urandom, $urandom, $urandom, $urandom};
            idx = slv_idx(cur.addr);
            if (!ARESET && PSEL != 0 && !PENABLE) begin
                chk("setup_psel", 64'(PSEL), 64'(4'(1) << idx));
                chk("setup_paddr", 64'(PADDR), 64'(cur.addr));
                chk("setup_pwrite", 64'(PWRITE), 64'(cur.wr));
                if (cur.wr) chk("setup_pwdata", 64'(PWDATA), 64'(cur.data));
                wl = cur.waits;
            end else if (!ARESET && PENABLE && idx < NS) begin
                if (wl == 0) begin
                    PREADY[idx]  = 1'b1;
                    PSLVERR[idx] = cur.err;
                    PRDATA[idx*DW +: DW] = cur.rdata;
                end else begin
                    PREADY[idx] = 1'b0;
                    wl--;
                end
            end
            #1;
            if (!ARESET) begin
                if (wcmd_rd_en && rcmd_rd_en) fail_now("double_grant");
                if (wcmd_rd_en) begin
                    chk("wgrant_elig", 64'({wcmd_empty, bresp_valid}), 64'(0));
                    if (wq.size() > 0) begin
                        cur = wq.pop_front();
                        wgnt.push_back(cyc);
                        glog.push_back(1'b1);
                    end
                end
                if (rcmd_rd_en) begin
                    chk("rgrant_elig", 64'({rcmd_empty, rdata_full}), 64'(0));
                    if (rq.size() > 0) begin
                        cur = rq.pop_front();
                        rgnt.push_back(cyc);
                        glog.push_back(1'b0);
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a result appears.
    initial begin
        bit   prev;
        exp_t e;
        int   g;
        prev = 1'b0;
        forever begin
            @(negedge ACLK);
            #2;
            if (ARESET) begin
                prev = 1'b0;
                continue;
            end
            if (rdata_wr_en) begin
                if (rexp.size() == 0 || rgnt.size() == 0) begin
                    fail_now("unexpected_rpush");
                end else begin
                    e = rexp.pop_front();
                    g = rgnt.pop_front();
                    chk("rdata", 64'(rdata_wdata), 64'(e.data));
                    chk("rresp", 64'(rdata_resp), 64'(e.resp));
                    chk("rlat", 64'(cyc - g), 64'(e.lat));
                end
            end
            if (bresp_valid && !prev) begin
                if (wexp.size() == 0 || wgnt.size() == 0) begin
                    fail_now("unexpected_bresp");
                end else begin
                    e = wexp.pop_front();
                    g = wgnt.pop_front();
                    chk("bresp", 64'(bresp_resp), 64'(e.resp));
                    chk("blat", 64'(cyc - g), 64'(e.lat));
                end
            end
            prev = bresp_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic flush();
        wq.delete(); rq.delete(); wexp.delete(); rexp.delete();
        wgnt.delete(); rgnt.delete(); glog.delete();
    endtask

    task automatic step();
        @(negedge ACLK);
        #3;
    endtask

    task automatic do_reset();
        step();
        ARESET = 1'b1;
        flush();
        step();
        step();
        ARESET = 1'b0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((wq.size() != 0 || rq.size() != 0 || wexp.size() != 0 ||
                rexp.size() != 0 || bresp_valid) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) fail_now("drain_timeout");
    endtask

    initial begin
        int idx, r, waits;
        logic [31:0] a;
        repeat (3) @(negedge ACLK);
        #3;
        chk("rst_psel", 64'(PSEL), 64'(0));
        chk("rst_penable", 64'(PENABLE), 64'(0));
        chk("rst_pwrite", 64'(PWRITE), 64'(0));
        chk("rst_paddr", 64'(PADDR), 64'(0));
        chk("rst_bvalid", 64'(bresp_valid), 64'(0));
        chk("rst_rpush", 64'(rdata_wr_en), 64'(0));
        chk("rst_rden", 64'({wcmd_rd_en, rcmd_rd_en}), 64'(0));
        ARESET = 1'b0;

        // Directed: plain write, read with wait states, decode errors,
        // timeout, slave error.
        issue(1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 0);
        drain(50);
        issue(0, 32'h0000_2010, 0, 3, 0, 32'h1234_5678);
        drain(50);
        issue(0, 32'h0000_4000, 0, 0, 0, 32'hAAAA_5555);
        drain(50);
        issue(1, 32'h0000_7008, 32'h0BAD_F00D, 0, 0, 0);
        drain(50);
        issue(0, 32'h0000_3000, 0, 1000, 0, 32'h5555_AAAA);
        drain(400);
        issue(1, 32'h0000_3004, 32'h0000_0042, 1, 1, 0);
        drain(50);

        // Arbitration alternates, write first after reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(1, 32'h0000_0000 | (i << LSB), 32'h100 + i, 1, 0, 0);
            issue(0, 32'h0000_0020 | (i << LSB), 0, 1, 0, 32'h200 + i);
        end
        drain(300);
        chk("alt_count", 64'(glog.size()), 64'(8));
        for (int i = 0; i < 8; i++) begin
            chk("alt_order", 64'(glog[i]), 64'((i % 2) == 0));
        end

        // Pending BRESP blocks writes but not reads.
        glog.delete();
        bready_mode = 0;
        issue(1, 32'h0000_1100, 32'h11, 0, 0, 0);
        issue(1, 32'h0000_2100, 32'h22, 0, 0, 0);
        issue(0, 32'h0000_3100, 0, 0, 0, 32'h33);
        issue(0, 32'h0000_0100, 0, 2, 0, 32'h44);
        repeat (40) step();
        chk("stall_count", 64'(glog.size()), 64'(3));
        chk("stall_g0", 64'(glog[0]), 64'(1));
        chk("stall_g1", 64'(glog[1]), 64'(0));
        chk("stall_g2", 64'(glog[2]), 64'(0));
        chk("stall_wq", 64'(wq.size()), 64'(1));
        bready_mode = 1;
        drain(100);

        // Reset in the middle of ACCESS.
        issue(0, 32'h0000_1000, 0, 1000, 0, 32'h77);
        r = 0;
        while (!PENABLE && r < 20) begin
            step();
            r++;
        end
        chk("mid_access", 64'(PENABLE), 64'(1));
        ARESET = 1'b1;
        flush();
        step();
        chk("mid_psel", 64'(PSEL), 64'(0));
        chk("mid_penable", 64'(PENABLE), 64'(0));
        ARESET = 1'b0;
        repeat (300) step();

        // Randomized traffic.
        full_rand = 1'b1;
        bready_mode = 2;
        for (int k = 0; k < 3000; k++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                if ((d == 0 ? wq.size() : rq.size()) < 3 &&
                    $urandom_range(0, 2) == 0) begin
                    idx = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3)
                                                     : $urandom_range(4, 7);
                    a = ($urandom & ~32'h7000) | (32'(idx) << LSB);
                    r = $urandom_range(0, 99);
                    waits = (r < 2) ? 300 :
                            (r < 30) ? 0 : $urandom_range(1, 4);
                    issue(d == 0, a, $urandom, waits,
                          $urandom_range(0, 3) == 0, $urandom);
                end
            end
        end
        full_rand = 1'b0;
        bready_mode = 1;
        drain(3000);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
